// File: rtl/pc_fetch_pkg.sv
`default_nettype none
// ============================================================================
// pc_fetch_pkg : shared widths, reset PC and enums for the fetch stage
// Revision 1.0
// ============================================================================
package pc_fetch_pkg;

    localparam int Data       = 32;
    localparam int InstrWidth = 32;

    localparam logic [Data-1:0] ResetPcDefault = 32'h0000_3000;
    localparam logic [Data-1:0] PcStep         = Data'(InstrWidth >> 3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2,
        HOLD  = 2'd3
    } fetch_state_e;

    typedef enum logic [2:0] {
        COP0_NONE    = 3'd0,
        COP0_MFC0    = 3'd1,
        COP0_MTC0    = 3'd2,
        COP0_ERET    = 3'd3,
        COP0_EXCEPT  = 3'd4
    } cop0_code_e;

    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_BP      = 5'd9,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

endpackage
`default_nettype wire

// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
// pc_fetch : instruction fetch FSM with redirect flush and downstream stall
// Revision 1.0
// ============================================================================
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [Data-1:0] ResetPc = ResetPcDefault
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            eJump,
    input  logic [Data-1:0] epc,
    input  logic            branch,
    input  logic [Data-1:0] branchTarget,
    output logic            iReq,
    output logic [Data-1:0] iAddr,
    input  logic            iAck,
    input  logic [Data-1:0] iData,
    output logic [Data-1:0] instr,
    output logic [Data-1:0] instrPc,
    output logic            instrValid
);

    fetch_state_e    state, state_next;
    logic [Data-1:0] pc, pc_next;
    logic [Data-1:0] pending, pending_next;
    logic [Data-1:0] instr_next, instr_pc_next;
    logic            valid_next;
    logic            redirect;
    logic [Data-1:0] target;

    // epc may float when eJump is low, so it is only ever selected under eJump
    assign redirect = eJump | branch;
    assign target   = eJump ? epc : branchTarget;

    // pc only moves on an acknowledged fetch, so it is the outstanding address
    assign iReq  = (state == REQ) || (state == FLUSH);
    assign iAddr = pc;

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        pending_next  = pending;
        instr_next    = instr;
        instr_pc_next = instrPc;
        valid_next    = instrValid;

        unique case (state)
            IDLE: begin
                valid_next = 1'b0;
                state_next = REQ;
            end
            REQ: begin
                valid_next = 1'b0;
                if (iAck && !redirect) begin
                    instr_next    = iData;
                    instr_pc_next = pc;
                    valid_next    = 1'b1;
                    pc_next       = pc + PcStep;
                    state_next    = stall ? HOLD : REQ;
                end else if (iAck) begin
                    pc_next = target;
                end else if (redirect) begin
                    pending_next = target;
                    state_next   = FLUSH;
                end
            end
            FLUSH: begin
                valid_next = 1'b0;
                if (iAck) begin
                    pc_next    = redirect ? target : pending;
                    state_next = REQ;
                end else if (redirect) begin
                    pending_next = target;
                end
            end
            HOLD: begin
                if (redirect) begin
                    valid_next = 1'b0;
                    pc_next    = target;
                    state_next = REQ;
                end else if (!stall) begin
                    valid_next = 1'b0;
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pc         <= ResetPc;
            pending    <= '0;
            instr      <= '0;
            instrPc    <= '0;
            instrValid <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            pending    <= pending_next;
            instr      <= instr_next;
            instrPc    <= instr_pc_next;
            instrValid <= valid_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// ============================================================================
// tb_pc_fetch : directed scenarios plus randomized traffic against a fetch model
// Revision 1.0
// ============================================================================
module tb_pc_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        eJump = 1'b0;
    logic [31:0] epc = '0;
    logic        branch = 1'b0;
    logic [31:0] branchTarget = '0;
    logic        iAck = 1'b0;
    logic [31:0] iData = '0;
    logic        iReq;
    logic [31:0] iAddr;
    logic [31:0] instr;
    logic [31:0] instrPc;
    logic        instrValid;

    int errors = 0;
    int checks = 0;
    bit run = 1'b1;

    pc_fetch #(.ResetPc(RESET_PC)) dut (
        .clock(clock), .reset(reset), .stall(stall), .eJump(eJump), .epc(epc),
        .branch(branch), .branchTarget(branchTarget), .iReq(iReq), .iAddr(iAddr),
        .iAck(iAck), .iData(iData), .instr(instr), .instrPc(instrPc),
        .instrValid(instrValid)
    );

    always #5 clock = ~clock;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: fetcher is either waking up, requesting, chasing a redirect
    // behind an outstanding request, or parked on a delivered word.
    bit          m_waking, m_parked, m_chasing, m_valid;
    logic [31:0] m_pc, m_chase, m_instr, m_ipc;

    always @(posedge clock or negedge reset) begin
        logic        red;
        logic [31:0] tgt;
        if (!reset) begin
            m_waking = 1; m_parked = 0; m_chasing = 0; m_valid = 0;
            m_pc = RESET_PC; m_chase = 0; m_instr = 0; m_ipc = 0;
        end else begin
            red = eJump | branch;
            tgt = eJump ? epc : branchTarget;
            if (m_waking) begin
                m_waking = 0;
                m_valid  = 0;
            end else if (m_parked) begin
                if (red) begin
                    m_parked = 0; m_valid = 0; m_pc = tgt;
                end else if (!stall) begin
                    m_parked = 0; m_valid = 0;
                end
            end else if (m_chasing) begin
                m_valid = 0;
                if (iAck) begin
                    m_pc = red ? tgt : m_chase;
                    m_chasing = 0;
                end else if (red) begin
                    m_chase = tgt;
                end
            end else begin
                m_valid = 0;
                if (iAck && !red) begin
                    m_instr = iData; m_ipc = m_pc; m_valid = 1;
                    m_pc = m_pc + 32'd4;
                    m_parked = stall;
                end else if (iAck) begin
                    m_pc = tgt;
                end else if (red) begin
                    m_chase = tgt;
                    m_chasing = 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        bit exp_req;
        if (run) begin
            exp_req = !m_waking && !m_parked;
            chk("iReq", iReq, exp_req);
            if (exp_req) chk("iAddr", iAddr, m_pc);
            chk("instrValid", instrValid, m_valid);
            if (m_valid) begin
                chk("instr", instr, m_instr);
                chk("instrPc", instrPc, m_ipc);
            end
        end
    end

    task automatic cyc(input logic s, input logic ej, input logic [31:0] e,
                       input logic br, input logic [31:0] bt,
                       input logic ack, input logic [31:0] d);
        stall = s; eJump = ej; epc = e; branch = br; branchTarget = bt;
        iAck = ack; iData = d;
        @(negedge clock); #1;
    endtask

    task automatic go(input logic ack, input logic [31:0] d);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, ack, d);
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_iReq"}, iReq, 0);
        chk({tag, "_iAddr"}, iAddr, RESET_PC);
        chk({tag, "_valid"}, instrValid, 0);
        chk({tag, "_instr"}, instr, 0);
        chk({tag, "_instrPc"}, instrPc, 0);
    endtask

    function automatic logic [31:0] raddr();
        if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFF0 | ($urandom & 32'hC);
        return $urandom & 32'hFFFF_FFFC;
    endfunction

    initial begin
        @(negedge clock); #1;
        chk_reset("rst0");
        reset = 1'b1;

        // Sequential fetch, ack one cycle after each request
        go(0, 0);
        chk("seq_req", iReq, 1); chk("seq_addr0", iAddr, 32'h3000); chk("seq_v0", instrValid, 0);
        go(0, 0); go(1, 32'h1111_0000);
        chk("seq_v1", instrValid, 1); chk("seq_pc1", instrPc, 32'h3000);
        chk("seq_i1", instr, 32'h1111_0000); chk("seq_addr1", iAddr, 32'h3004);
        go(0, 0);
        chk("seq_pulse", instrValid, 0);
        go(1, 32'h1111_0004);
        chk("seq_pc2", instrPc, 32'h3004); chk("seq_addr2", iAddr, 32'h3008);
        go(0, 0); go(1, 32'h1111_0008);
        chk("seq_pc3", instrPc, 32'h3008); chk("seq_addr3", iAddr, 32'h300C);

        // Stall into HOLD on the 3004 delivery
        reset = 1'b0; go(0, 0); reset = 1'b1;
        go(0, 0); go(0, 0); go(1, 32'hA000_0000); go(0, 0);
        cyc(1, 0, 0, 0, 0, 1, 32'hA000_0004);
        chk("hold_v", instrValid, 1); chk("hold_pc", instrPc, 32'h3004);
        chk("hold_i", instr, 32'hA000_0004); chk("hold_req", iReq, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("hold2_v", instrValid, 1); chk("hold2_pc", instrPc, 32'h3004); chk("hold2_req", iReq, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("hold3_i", instr, 32'hA000_0004);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("unhold_v", instrValid, 0); chk("unhold_req", iReq, 1); chk("unhold_addr", iAddr, 32'h3008);

        // Branch while held and still stalled
        go(0, 0); cyc(1, 0, 0, 0, 0, 1, 32'hA000_0008);
        chk("hold4_pc", instrPc, 32'h3008);
        cyc(1, 0, 0, 1, 32'h3200, 0, 0);
        chk("hbr_v", instrValid, 0); chk("hbr_req", iReq, 1); chk("hbr_addr", iAddr, 32'h3200);

        // Exception redirect with the request still outstanding
        cyc(0, 1, 32'h4180, 0, 0, 0, 0);
        chk("fl_req", iReq, 1); chk("fl_addr", iAddr, 32'h3200); chk("fl_v", instrValid, 0);
        go(0, 0);
        chk("fl_addr2", iAddr, 32'h3200);
        go(1, 32'hDEAD_3200);
        chk("fl_drop", instrValid, 0); chk("fl_new", iAddr, 32'h4180);

        // eJump beats branch when both land with iAck
        go(0, 0);
        cyc(0, 1, 32'h4180, 1, 32'h3100, 1, 32'hDEAD_4180);
        chk("pri_drop", instrValid, 0); chk("pri_addr", iAddr, 32'h4180);
        go(1, 32'hB000_4180);
        chk("pri_pc", instrPc, 32'h4180); chk("pri_addr2", iAddr, 32'h4184);

        // pc wraps at the top of the address space
        cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        go(1, 32'hDEAD_4184);
        chk("wrap_at", iAddr, 32'hFFFF_FFFC);
        go(1, 32'hC000_FFFC);
        chk("wrap_pc", instrPc, 32'hFFFF_FFFC); chk("wrap_addr", iAddr, 32'h0);

        // Reset while flushing, with iAck pulsed during reset and in IDLE
        cyc(0, 0, 0, 1, 32'h3300, 0, 0);
        chk("rf_req", iReq, 1);
        reset = 1'b0; iAck = 1'b1; iData = 32'hBAD0_BAD0;
        @(negedge clock); #1;
        chk_reset("rst1");
        iAck = 1'b0;
        @(negedge clock); #1;
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 1, 32'hBAD1_BAD1);
        chk("rr_req", iReq, 1); chk("rr_addr", iAddr, 32'h3000); chk("rr_v", instrValid, 0);
        go(0, 0);
        chk("rr_nostale", instrValid, 0); chk("rr_addr2", iAddr, 32'h3000);

        // Randomized traffic, checked every cycle against the reference
        for (int i = 0; i < 4000; i++) begin
            logic        s, ej, br, ack;
            logic [31:0] e, bt;
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b0;
                iAck = 1'($urandom_range(0, 1));
                @(negedge clock); #1;
                reset = 1'b1;
                continue;
            end
            s   = ($urandom_range(0, 2) == 0);
            ej  = ($urandom_range(0, 11) == 0);
            br  = ($urandom_range(0, 7) == 0);
            e   = ej ? raddr() : (($urandom_range(0, 1) == 0) ? 32'hzzzz_zzzz : $urandom);
            bt  = raddr();
            ack = iReq && ($urandom_range(0, 1) == 1);
            cyc(s, ej, e, br, bt, ack, $urandom);
        end

        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
